dm_wbuf: RTL and testbench

DM_WBUF -- requirements
Module: dm_wbuf

---
 rtl/dm_wbuf.sv | 133 +++++++++++++
 tb/tb_dm_wbuf.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_wbuf.sv
// Data-memory store buffer: a circular FIFO of word stores that drains into dm
// when the port is free, with per-byte-lane store-to-load forwarding.
// Optional macro WBUF_MERGE_EN merges a store into the youngest entry on a word match.
`timescale 1ns/1ps

module dm_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [3:0]    st_be,
    output logic          st_ready,
    input  logic [31:0]   ld_addr,
    output logic [3:0]    ld_fwd_be,
    output logic [31:0]   ld_fwd_data,
    input  logic          dm_busy,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic [3:0]    dm_be,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    ptr_t          head, tail, young;
    logic [CW-1:0] count;
    logic [AW-1:0] e_addr [DEPTH];
    logic [31:0]   e_data [DEPTH];
    logic [3:0]    e_be   [DEPTH];
    logic [DEPTH-1:0] e_valid;

    logic [AW-1:0] st_word, ld_word;
    logic          full, push, pop;
    logic          unused_addr_bits;

    assign st_word = st_addr[AW+1:2];
    assign ld_word = ld_addr[AW+1:2];
    assign unused_addr_bits = ^{st_addr[31:AW+2], st_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign young = tail - ptr_t'(1);

`ifdef WBUF_MERGE_EN
    logic young_hit, merge;

    // A full buffer can still take a store that lands on the youngest word.
    assign young_hit = e_valid[young] && (e_addr[young] == st_word);
    assign st_ready  = !full || young_hit;
    assign merge     = st_valid && young_hit && (st_be != 4'b0000) && !(pop && (young == head));
    assign push      = st_valid && st_ready && (st_be != 4'b0000) && !merge;
`else
    assign st_ready = !full;
    assign push     = st_valid && st_ready && (st_be != 4'b0000);
`endif

    // Drain side: head entry goes to dm whenever a load is not using the port.
    assign dm_we    = !empty && !dm_busy;
    assign pop      = dm_we;
    assign dm_addr  = empty ? '0 : e_addr[head];
    assign dm_wdata = empty ? '0 : e_data[head];
    assign dm_be    = empty ? '0 : e_be[head];

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        ptr_t idx;
        idx         = '0;
        ld_fwd_be   = '0;
        ld_fwd_data = '0;
        // Walk oldest to youngest so the youngest matching entry wins each lane.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + ptr_t'(i);
            if (e_valid[idx] && (e_addr[idx] == ld_word)) begin
                for (int k = 0; k < 4; k++) begin
                    if (e_be[idx][k]) begin
                        ld_fwd_be[k]          = 1'b1;
                        ld_fwd_data[8*k +: 8] = e_data[idx][8*k +: 8];
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            if (push) begin
                tail           <= tail + ptr_t'(1);
                e_valid[tail]  <= 1'b1;
            end
            if (pop) begin
                head           <= head + ptr_t'(1);
                e_valid[head]  <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry payload is not reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= st_word;
            e_data[tail] <= st_data;
            e_be[tail]   <= st_be;
        end
`ifdef WBUF_MERGE_EN
        if (merge) begin
            for (int k = 0; k < 4; k++) begin
                if (st_be[k]) e_data[young][8*k +: 8] <= st_data[8*k +: 8];
            end
            e_be[young] <= e_be[young] | st_be;
        end
`endif
    end

endmodule

// File: tb/tb_dm_wbuf.sv
// Self-checking bench for dm_wbuf: queue-based reference model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_dm_wbuf;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          st_valid = 1'b0;
    logic [31:0]   st_addr = '0;
    logic [31:0]   st_data = '0;
    logic [3:0]    st_be = '0;
    logic          st_ready;
    logic [31:0]   ld_addr = '0;
    logic [3:0]    ld_fwd_be;
    logic [31:0]   ld_fwd_data;
    logic          dm_busy = 1'b0;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [3:0]    dm_be;
    logic          empty;

    always #5 clk = ~clk;

    dm_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_fwd_be(ld_fwd_be), .ld_fwd_data(ld_fwd_data),
        .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .empty(empty)
    );

    typedef struct packed {
        logic [AW-1:0] w;
        logic [31:0]   d;
        logic [3:0]    be;
    } ent_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
        int            cyc;
    } wr_t;

    ent_t q[$];
    wr_t  wlog[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   base;

`ifdef WBUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: a queue of pending word stores, oldest first.
    always @(negedge clk) begin : model
        logic [AW-1:0] w_st, w_ld;
        logic          rdy, we, mrg;
        logic [3:0]    fb;
        logic [31:0]   fd;
        ent_t          e;
        if (rst) begin
            q.delete();
            check("rst_st_ready", st_ready, 1);
            check("rst_empty", empty, 1);
            check("rst_dm_we", dm_we, 0);
            check("rst_dm_be", dm_be, 0);
            check("rst_fwd_be", ld_fwd_be, 0);
            check("rst_fwd_data", ld_fwd_data, 0);
        end else begin
            w_st = st_addr[AW+1:2];
            w_ld = ld_addr[AW+1:2];
            rdy  = (q.size() < DEPTH);
            if (MERGE && q.size() > 0 && q[$].w == w_st) rdy = 1'b1;
            we = (q.size() > 0) && !dm_busy;
            fb = '0;
            fd = '0;
            foreach (q[i]) begin
                for (int k = 0; k < 4; k++) begin
                    if (q[i].w == w_ld && q[i].be[k]) begin
                        fb[k]          = 1'b1;
                        fd[8*k +: 8]   = q[i].d[8*k +: 8];
                    end
                end
            end
            check("st_ready", st_ready, rdy);
            check("empty", empty, q.size() == 0);
            check("dm_we", dm_we, we);
            check("ld_fwd_be", ld_fwd_be, fb);
            check("ld_fwd_data", ld_fwd_data, fd);
            if (we) begin
                check("dm_addr", dm_addr, q[0].w);
                check("dm_wdata", dm_wdata, q[0].d);
                check("dm_be", dm_be, q[0].be);
            end
            if (q.size() == 0) check("dm_be_idle", dm_be, 0);
            if (dm_we) wlog.push_back('{a: dm_addr, d: dm_wdata, be: dm_be, cyc: cycle});

            if (st_valid && rdy && st_be != 4'b0000) begin
                mrg = MERGE && q.size() > 0 && q[$].w == w_st && !(we && q.size() == 1);
                if (mrg) begin
                    e = q[$];
                    for (int k = 0; k < 4; k++)
                        if (st_be[k]) e.d[8*k +: 8] = st_data[8*k +: 8];
                    e.be  = e.be | st_be;
                    q[$]  = e;
                end else begin
                    q.push_back('{w: w_st, d: st_data, be: st_be});
                end
            end
            if (we) void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
    endtask

    task automatic idle_st();
        st_valid = 1'b0;
        st_be    = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("reset_lit_ready", st_ready, 1);
        check("reset_lit_empty", empty, 1);
        rst = 1'b0;
        tick();

        // Single store held while busy, then drained.
        base    = wlog.size();
        dm_busy = 1'b1;
        drive_st(32'h10, 32'h1122_3344, 4'hF);
        #1 check("s1_no_we", dm_we, 0);
        tick();
        idle_st();
        #1 check("s1_busy_hold", dm_we, 0);
        dm_busy = 1'b0;
        ld_addr = 32'h10;
        #1;
        check("s1_we", dm_we, 1);
        check("s1_addr", dm_addr, 4);
        check("s1_wdata", dm_wdata, 32'h1122_3344);
        check("s1_fwd_popped", ld_fwd_be, 4'hF);
        tick();
        check("s1_empty", empty, 1);
        check("s1_nwrites", wlog.size() - base, 1);

        // Fill to capacity, fifth store held, in-order drain one per cycle.
        base    = wlog.size();
        dm_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_st(32'(i * 4), 32'hA000 + 32'(i), 4'hF);
            #1 check("s2_ready", st_ready, (i < 4));
            tick();
        end
        idle_st();
        dm_busy = 1'b0;
        repeat (6) tick();
        check("s2_nwrites", wlog.size() - base, 4);
        for (int j = 0; j < 4 && base + j < wlog.size(); j++) begin
            check("s2_order", wlog[base+j].a, j);
            check("s2_rate", wlog[base+j].cyc - wlog[base].cyc, j);
        end

        // Partial-lane stores to one word: forwarding and merge behaviour.
        base    = wlog.size();
        dm_busy = 1'b1;
        ld_addr = 32'h20;
        drive_st(32'h20, 32'hAABB_CCDD, 4'b0011);
        tick();
        drive_st(32'h20, 32'h1111_0000, 4'b1100);
        #1;
        check("s3_same_cycle_be", ld_fwd_be, 4'b0011);
        check("s3_same_cycle_data", ld_fwd_data, 32'h0000_CCDD);
        tick();
        idle_st();
        #1;
        check("s3_fwd_be", ld_fwd_be, 4'b1111);
        check("s3_fwd_data", ld_fwd_data, 32'h1111_CCDD);
        ld_addr = 32'h24;
        #1 check("s3_fwd_miss", ld_fwd_be, 0);
        dm_busy = 1'b0;
        repeat (4) tick();
        if (MERGE) begin
            check("s3m_nwrites", wlog.size() - base, 1);
            if (wlog.size() > base) begin
                check("s3m_be", wlog[base].be, 4'b1111);
                check("s3m_data", wlog[base].d, 32'h1111_CCDD);
                check("s3m_addr", wlog[base].a, 8);
            end
        end else begin
            check("s3_nwrites", wlog.size() - base, 2);
            if (wlog.size() > base + 1) begin
                check("s3_be0", wlog[base].be, 4'b0011);
                check("s3_be1", wlog[base+1].be, 4'b1100);
                check("s3_data0", wlog[base].d, 32'hAABB_CCDD);
            end
        end

        // Store with no byte enables is swallowed.
        base    = wlog.size();
        dm_busy = 1'b1;
        drive_st(32'h30, 32'hDEAD_BEEF, 4'b0000);
        tick();
        idle_st();
        #1 check("s4_empty", empty, 1);
        dm_busy = 1'b0;
        repeat (2) tick();
        check("s4_nwrites", wlog.size() - base, 0);

        // Reset with stores pending discards them.
        dm_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_st(32'h40 + 32'(4 * i), 32'h5000 + 32'(i), 4'hF);
            tick();
        end
        idle_st();
        #1 check("s5_pending", empty, 0);
        rst = 1'b1;
        #1;
        check("s5_rst_empty", empty, 1);
        check("s5_rst_ready", st_ready, 1);
        check("s5_rst_we", dm_we, 0);
        tick();
        rst     = 1'b0;
        base    = wlog.size();
        dm_busy = 1'b0;
        ld_addr = 32'h40;
        #1 check("s5_fwd_gone", ld_fwd_be, 0);
        repeat (5) tick();
        check("s5_nwrites", wlog.size() - base, 0);

        // Full while draining: new store waits one cycle, then goes in.
        base    = wlog.size();
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(32'h40 + 32'(4 * i), 32'h6000 + 32'(i), 4'hF);
            tick();
        end
        dm_busy = 1'b0;
        drive_st(32'h80, 32'hC0DE_0080, 4'hF);
        #1;
        check("s6_not_ready", st_ready, 0);
        check("s6_draining", dm_we, 1);
        tick();
        check("s6_ready_next", st_ready, 1);
        tick();
        idle_st();
        repeat (6) tick();
        check("s6_nwrites", wlog.size() - base, 5);
        if (wlog.size() >= base + 5) begin
            for (int j = 0; j < 4; j++) check("s6_order", wlog[base+j].a, 32'h10 + 32'(j));
            check("s6_last", wlog[base+4].a, 32'h20);
            check("s6_last_data", wlog[base+4].d, 32'hC0DE_0080);
        end

        // Youngest matching entry wins per lane; same-cycle store not visible.
        base    = wlog.size();
        dm_busy = 1'b1;
        ld_addr = 32'h30;
        drive_st(32'h30, 32'h0102_0304, 4'hF);
        tick();
        drive_st(32'h50, 32'h5555_5555, 4'hF);
        tick();
        drive_st(32'h30, 32'hA0B0_C0D0, 4'b0101);
        tick();
        drive_st(32'h30, 32'hFFFF_FFFF, 4'hF);
        #1;
        check("s7_fwd_be", ld_fwd_be, 4'hF);
        check("s7_fwd_data", ld_fwd_data, 32'h01B0_03D0);
        tick();
        idle_st();
        #1 check("s7_fwd_newest", ld_fwd_data, 32'hFFFF_FFFF);
        dm_busy = 1'b0;
        repeat (6) tick();
        check("s7_nwrites", wlog.size() - base, MERGE ? 3 : 4);

        // Store hitting the youngest word while full.
        base    = wlog.size();
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(32'h60 + 32'(4 * i), 32'h7000 + 32'(i), 4'hF);
            tick();
        end
        drive_st(32'h6C, 32'h0000_AB00, 4'b0010);
        #1 check("s8_full_hit_ready", st_ready, MERGE);
        tick();
        idle_st();
        dm_busy = 1'b0;
        repeat (6) tick();
        check("s8_nwrites", wlog.size() - base, 4);
        if (wlog.size() >= base + 4)
            check("s8_last_data", wlog[base+3].d, MERGE ? 32'h0000_AB03 : 32'h0000_7003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
